// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and sizes for the multiply/divide unit.
//   mdu_op_t    - request opcode (MULTU, MULT, DIVU, DIV)
//   mdu_state_t - mdu control states
//   mdu_mag     - magnitude helper used when capturing signed operands
package cpu_types_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_ITER  = 32;
  // 33-bit upper field (carry / partial remainder) plus 32-bit lower field
  localparam int unsigned MDU_ACC_W = 2 * MDU_WIDTH + 1;
  localparam int unsigned MDU_CNT_W = 5;

  typedef enum logic [1:0] {
    MULTU = 2'd0,
    MULT  = 2'd1,
    DIVU  = 2'd2,
    DIV   = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // Two's-complement magnitude when sgn is set; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [MDU_WIDTH-1:0] mdu_mag(input logic [MDU_WIDTH-1:0] x,
                                                   input logic sgn);
    logic [MDU_WIDTH-1:0] r;
    r = x;
    if (sgn && x[MDU_WIDTH-1]) r = (~x) + 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one combinational iteration of the multiply/divide datapath.
//   acc_i     - current accumulator {upper[32:0], lower[31:0]}
//   operand_i - multiplicand (multiply) or divisor (divide), unsigned magnitude
//   op_i      - captured opcode; op_i[1] selects divide
//   acc_o     - accumulator after this iteration
// Build option: MDU_DIV_EN compiles the restoring-divide step; without it a
// divide op simply holds the accumulator (the top never iterates a divide).
module mdu_iter
  import cpu_types_pkg::*;
(
  input  logic [MDU_ACC_W-1:0] acc_i,
  input  logic [MDU_WIDTH-1:0] operand_i,
  input  logic [1:0]           op_i,
  output logic [MDU_ACC_W-1:0] acc_o
);

  logic                 is_div;
  logic [MDU_WIDTH:0]   sum;
  logic [MDU_ACC_W-1:0] mul_acc;
`ifdef MDU_DIV_EN
  logic [MDU_ACC_W-1:0] shl;
  logic [MDU_WIDTH:0]   trial;
  logic [MDU_ACC_W-1:0] div_acc;
`endif

  assign is_div = (op_i == DIVU) || (op_i == DIV);

  // Shift-add multiply: conditional add into the upper field, then shift right.
  always_comb begin
    sum     = {1'b0, acc_i[63:32]} + {1'b0, operand_i};
    mul_acc = {1'b0, acc_i[MDU_ACC_W-1:1]};
    if (acc_i[0]) mul_acc = {1'b0, sum, acc_i[31:1]};
  end

`ifdef MDU_DIV_EN
  // Restoring divide: shift {rem,quo} left, keep the subtraction if it did not borrow.
  always_comb begin
    shl     = {acc_i[63:0], 1'b0};
    trial   = shl[MDU_ACC_W-1:32] - {1'b0, operand_i};
    div_acc = shl;
    if (!trial[MDU_WIDTH]) div_acc = {trial, shl[31:1], 1'b1};
  end

  assign acc_o = is_div ? div_acc : mul_acc;
`else
  assign acc_o = is_div ? acc_i : mul_acc;
`endif

endmodule

// File: rtl/mdu.sv
// mdu: iterative 32-bit multiply/divide unit with valid/ready request and
// response handshakes.
//   CLK, RST                 - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake; op, portA, portB captured on accept
//   resp_valid/resp_ready    - response handshake; hi, lo, div_zero held until taken
//   hi/lo                    - product[63:32]/[31:0], or remainder/quotient
// Build option: MDU_DIV_EN enables the divide datapath. Without it, DIVU/DIV
// complete in one cycle with hi=0, lo=0, div_zero=1.
module mdu
  import cpu_types_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  mdu_state_t           state_q;
  logic [MDU_CNT_W-1:0] cnt_q;
  logic [MDU_ACC_W-1:0] acc_q;
  logic [MDU_ACC_W-1:0] acc_d;
  logic [WIDTH-1:0]     operand_q;
  logic [1:0]           op_q;
  logic                 neg_q;
`ifdef MDU_DIV_EN
  logic                 rem_neg_q;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
`endif
  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic                 div_zero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   prod_fix;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign div_zero   = div_zero_q;

  // Magnitudes only for signed ops (op[0]).
  assign mag_a = mdu_mag(portA, op[0]);
  assign mag_b = mdu_mag(portB, op[0]);

  mdu_iter u_iter (
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .op_i      (op_q),
    .acc_o     (acc_d)
  );

  // Sign fixup of the finished magnitude result.
  always_comb begin
    prod_fix = acc_q[63:0];
    if (neg_q) prod_fix = (~acc_q[63:0]) + 64'd1;
  end

`ifdef MDU_DIV_EN
  always_comb begin
    quo_fix = acc_q[31:0];
    rem_fix = acc_q[63:32];
    if (neg_q)     quo_fix = (~acc_q[31:0]) + 32'd1;
    if (rem_neg_q) rem_fix = (~acc_q[63:32]) + 32'd1;
  end
`endif

  // Control FSM, iteration counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      operand_q    <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
`ifdef MDU_DIV_EN
      rem_neg_q    <= 1'b0;
`endif
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      div_zero_q   <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q        <= op;
            cnt_q       <= '0;
            neg_q       <= op[0] & (portA[WIDTH-1] ^ portB[WIDTH-1]);
`ifdef MDU_DIV_EN
            rem_neg_q   <= op[0] & portA[WIDTH-1];
`endif
            req_ready_q <= 1'b0;
            if (op[1]) begin
`ifdef MDU_DIV_EN
              if (portB == '0) begin
                hi_q         <= portA;
                lo_q         <= '1;
                div_zero_q   <= 1'b1;
                resp_valid_q <= 1'b1;
                state_q      <= DONE;
              end else begin
                acc_q     <= {33'b0, mag_a};
                operand_q <= mag_b;
                state_q   <= BUSY;
              end
`else
              hi_q         <= '0;
              lo_q         <= '0;
              div_zero_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
`endif
            end else begin
              // Multiplier sits in the low half, multiplicand is added above it.
              acc_q     <= {33'b0, mag_b};
              operand_q <= mag_a;
              state_q   <= BUSY;
            end
          end
        end

        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + MDU_CNT_W'(1);
          if (cnt_q == MDU_CNT_W'(MDU_ITER - 1)) state_q <= FIX;
        end

        FIX: begin
`ifdef MDU_DIV_EN
          if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
`else
          hi_q <= prod_fix[63:32];
          lo_q <= prod_fix[31:0];
`endif
          div_zero_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end

        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for mdu with a cycle-level reference model.
module tb_mdu;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [31:0] portA;
  logic [31:0] portB;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mdu dut (
    .CLK        (clk),
    .RST        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .portA      (portA),
    .portB      (portB),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .hi         (hi),
    .lo         (lo),
    .div_zero   (div_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_dz(input logic [1:0] o, input logic [31:0] b);
    return o[1] && (!DIV_EN || b == 32'd0);
  endfunction

  // Returns {div_zero, hi, lo} computed with plain arithmetic.
  function automatic logic [64:0] golden(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0]        p;
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd1: begin p = sa * sb; return {1'b0, p}; end
      default: begin
        if (!DIV_EN) return {1'b1, 64'd0};
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'd2) return {1'b0, a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  logic        m_ready, m_valid, m_dz, m_clean;
  logic [31:0] m_hi, m_lo;
  logic [64:0] m_pend;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_dz <= 1'b0; m_clean <= 1'b1;
      m_hi <= '0; m_lo <= '0; m_cnt <= 0; m_pend <= '0;
    end else if (m_valid) begin
      if (resp_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_clean <= 1'b0;
        {m_dz, m_hi, m_lo} <= m_pend;
      end
    end else if (m_ready && req_valid) begin
      m_ready <= 1'b0;
      if (is_dz(op, portB)) begin
        m_valid <= 1'b1;
        m_clean <= 1'b0;
        {m_dz, m_hi, m_lo} <= golden(op, portA, portB);
      end else begin
        m_cnt  <= 33;
        m_pend <= golden(op, portA, portB);
      end
    end
  end

  // Compare every cycle; result fields only while they are meaningful.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, m_ready);
      chk("resp_valid", resp_valid, m_valid);
      if (m_valid || m_clean) begin
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("div_zero", div_zero, m_dz);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready", req_ready, 1'b1);
    req_valid = 1'b1; op = o; portA = a; portB = b;
    @(negedge clk);
    // Operands after the accept edge must not matter.
    req_valid = 1'b0; op = 2'($urandom); portA = $urandom; portB = $urandom;
  endtask

  task automatic wait_resp(input string name, input int exp_lat, input logic [31:0] eh,
                           input logic [31:0] el, input logic ed);
    int lat = 0;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    chk({name, "_dz"}, div_zero, ed);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("ready_after_handshake", req_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] h0, l0;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; op = 2'd0; portA = '0; portB = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dz", div_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(2'd0, 32'hFFFF_FFFF, 32'd2);
    wait_resp("multu", 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    consume();

    send(2'd1, 32'hFFFF_FFFD, 32'd5);
    wait_resp("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    consume();

    send(2'd1, 32'h8000_0000, 32'h8000_0000);
    wait_resp("mult_min", 33, 32'h4000_0000, 32'h0000_0000, 1'b0);
    consume();

    send(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_resp("div_neg", DIV_EN ? 33 : 0, DIV_EN ? 32'hFFFF_FFFF : 32'd0,
              DIV_EN ? 32'hFFFF_FFFD : 32'd0, !DIV_EN);
    consume();

    send(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_resp("div_ovf", DIV_EN ? 33 : 0, 32'd0,
              DIV_EN ? 32'h8000_0000 : 32'd0, !DIV_EN);
    consume();

    send(2'd2, 32'd1000, 32'd7);
    wait_resp("divu", DIV_EN ? 33 : 0, DIV_EN ? 32'd6 : 32'd0,
              DIV_EN ? 32'd142 : 32'd0, !DIV_EN);
    consume();

    send(2'd2, 32'd100, 32'd0);
    wait_resp("divu_zero", 0, DIV_EN ? 32'd100 : 32'd0,
              DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1'b1);
    consume();

    // Backpressure: result held, ready low, stray request ignored.
    send(2'd0, 32'h1234_5678, 32'h10);
    wait_resp("bp", 33, 32'h1, 32'h2345_6780, 1'b0);
    h0 = hi; l0 = lo;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2); op = 2'd0; portA = 32'd9; portB = 32'd9;
      @(negedge clk);
      chk("bp_hi_stable", hi, h0);
      chk("bp_lo_stable", lo, l0);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    // Request presented on the handshake cycle is only taken one edge later.
    req_valid = 1'b1; op = 2'd0; portA = 32'd3; portB = 32'd4; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hs_no_accept", resp_valid, 1'b0);
    chk("hs_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; portA = $urandom; portB = $urandom;
    wait_resp("after_hs", 33, 32'd0, 32'd12, 1'b0);
    consume();

    // Reset during BUSY discards the operation.
    send(2'd0, 32'hFFFF, 32'hFFFF);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    send(2'd0, 32'd6, 32'd7);
    wait_resp("after_rst", 33, 32'd0, 32'd42, 1'b0);
    consume();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
